// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : M pipeline stage: data-memory handshake, store lanes, load
//            alignment/extension and the W writeback register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_wb_en,
  input  logic [4:0]        ex_rd_index,
  input  logic [31:0]       alu_out,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [1:0]        remainder,
  input  logic [31:0]       rs2_data_out,
  output logic              dm_req,
  output logic [3:0]        dm_we,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ready,
  input  logic [31:0]       dm_rdata,
  output logic              mem_stall,
  output logic [31:0]       MEM_forward_data,
  output logic              misalign,
  output logic              wb_en,
  output logic [4:0]        wb_rd_index,
  output logic [31:0]       wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic              m_valid_q, m_load_q, m_store_q, m_wb_en_q;
  logic [2:0]        m_funct3_q;
  logic [4:0]        m_rd_q;
  logic [31:0]       m_alu_q, m_rs2_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [1:0]        m_rem_q;

  logic [1:0]        state_q, state_d;
  logic [31:0]       ld_q;
  logic              wb_en_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;

  logic              memop, aligned, req, stall;
  logic [3:0]        we_lane;
  logic [31:0]       wdata_lane, rdata_shift, ld_ext;

  assign memop = m_valid_q & (m_load_q | m_store_q);

  always_comb begin
    aligned = 1'b1;
    case (m_funct3_q[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (m_rem_q != 2'd3);
      default: aligned = (m_rem_q == 2'd0);
    endcase
  end

  // M register: the whole EXE bundle freezes while this stage stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q  <= 1'b0;
      m_load_q   <= 1'b0;
      m_store_q  <= 1'b0;
      m_wb_en_q  <= 1'b0;
      m_funct3_q <= 3'd0;
      m_rd_q     <= 5'd0;
      m_alu_q    <= 32'd0;
      m_rs2_q    <= 32'd0;
      m_addr_q   <= '0;
      m_rem_q    <= 2'd0;
    end else if (!stall) begin
      m_valid_q  <= ex_valid;
      m_load_q   <= ex_load;
      m_store_q  <= ex_store;
      m_wb_en_q  <= ex_wb_en;
      m_funct3_q <= ex_funct3;
      m_rd_q     <= ex_rd_index;
      m_alu_q    <= alu_out;
      m_rs2_q    <= rs2_data_out;
      m_addr_q   <= dm_addr;
      m_rem_q    <= remainder;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = dm_ready ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (dm_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        req   = memop & aligned;
        stall = memop & aligned;
      end
      S_BUSY: begin
        req   = 1'b1;
        stall = 1'b1;
      end
      default: begin
        req   = 1'b0;
        stall = 1'b0;
      end
    endcase
  end

  always_comb begin
    we_lane    = 4'b1111;
    wdata_lane = m_rs2_q;
    case (m_funct3_q[1:0])
      2'b00: begin
        we_lane    = 4'b0001 << m_rem_q;
        wdata_lane = {4{m_rs2_q[7:0]}};
      end
      2'b01: begin
        we_lane    = 4'b0011 << m_rem_q;
        wdata_lane = {2{m_rs2_q[15:0]}};
      end
      default: begin
        we_lane    = 4'b1111;
        wdata_lane = m_rs2_q;
      end
    endcase
  end

  assign rdata_shift = dm_rdata >> {m_rem_q, 3'b000};

  always_comb begin
    ld_ext = dm_rdata;
    case (m_funct3_q)
      3'b000:  ld_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  ld_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  ld_ext = {24'd0, rdata_shift[7:0]};
      3'b101:  ld_ext = {16'd0, rdata_shift[15:0]};
      default: ld_ext = dm_rdata;
    endcase
  end

  // rdata is only valid on the accepting cycle, so grab it there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q <= 32'd0;
    end else if (req && dm_ready) begin
      ld_q <= ld_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
    end else if (!stall) begin
      wb_en_q   <= m_valid_q & m_wb_en_q & ~misalign;
      wb_rd_q   <= m_rd_q;
      wb_data_q <= m_load_q ? ld_q : m_alu_q;
    end
  end

  assign dm_req           = req;
  assign dm_we            = (req && m_store_q) ? we_lane : 4'b0000;
  assign dm_addr_o        = m_addr_q;
  assign dm_wdata         = wdata_lane;
  assign mem_stall        = stall;
  assign misalign         = memop & ~aligned;
  assign MEM_forward_data = m_alu_q;
  assign wb_en            = wb_en_q;
  assign wb_rd_index      = wb_rd_q;
  assign wb_data          = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Scoreboard bench for mem_access_stage memory handshake and writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int AW = 14;

  typedef struct {
    logic          valid, load, store, wb;
    logic [2:0]    f3;
    logic [4:0]    rd;
    logic [31:0]   alu, rs2, rdata;
    logic [AW-1:0] addr;
    logic [1:0]    r;
    int            delay;
  } instr_t;

  typedef struct {
    logic          en, req, mis, store;
    logic [4:0]    rd;
    logic [31:0]   data, wdata, alu, rdata;
    logic [3:0]    we;
    logic [AW-1:0] addr;
    int            delay;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_load, ex_store, ex_wb_en;
  logic [2:0]    ex_funct3;
  logic [4:0]    ex_rd_index;
  logic [31:0]   alu_out, rs2_data_out, dm_rdata, dm_wdata, MEM_forward_data, wb_data;
  logic [AW-1:0] dm_addr, dm_addr_o;
  logic [1:0]    remainder;
  logic          dm_req, dm_ready, mem_stall, misalign, wb_en;
  logic [3:0]    dm_we;
  logic [4:0]    wb_rd_index;

  int     n_checks = 0;
  int     n_errors = 0;
  instr_t prog[$];
  exp_t   sb[$];
  logic   m_done = 1'b0;
  int     req_cnt = 0;
  logic   idle_ready = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_wb_en(ex_wb_en), .ex_rd_index(ex_rd_index),
    .alu_out(alu_out), .dm_addr(dm_addr), .remainder(remainder),
    .rs2_data_out(rs2_data_out),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr_o(dm_addr_o), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .MEM_forward_data(MEM_forward_data), .misalign(misalign),
    .wb_en(wb_en), .wb_rd_index(wb_rd_index), .wb_data(wb_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(logic v, logic ld, logic st, logic [2:0] f3, logic wb,
                                logic [4:0] rd, logic [31:0] alu, logic [AW-1:0] a,
                                logic [1:0] r, logic [31:0] rs2, int dly, logic [31:0] rdat);
    instr_t i;
    i.valid = v;   i.load = ld;  i.store = st; i.f3 = f3;   i.wb = wb;
    i.rd = rd;     i.alu = alu;  i.addr = a;   i.r = r;     i.rs2 = rs2;
    i.delay = dly; i.rdata = rdat;
    return i;
  endfunction

  function automatic exp_t mk_exp(instr_t i);
    exp_t e;
    logic ok, memop;
    logic [31:0] sh;
    case (i.f3[1:0])
      2'b00:   ok = 1'b1;
      2'b01:   ok = (i.r != 2'd3);
      default: ok = (i.r == 2'd0);
    endcase
    memop   = i.valid && (i.load || i.store);
    e.req   = memop && ok;
    e.mis   = memop && !ok;
    e.store = i.store;
    e.addr  = i.addr;
    e.alu   = i.alu;
    e.rdata = i.rdata;
    e.delay = i.delay;
    e.rd    = i.rd;
    e.en    = i.valid && i.wb && !e.mis;
    case (i.f3[1:0])
      2'b00:   begin e.we = 4'b0001 << i.r; e.wdata = {4{i.rs2[7:0]}};  end
      2'b01:   begin e.we = 4'b0011 << i.r; e.wdata = {2{i.rs2[15:0]}}; end
      default: begin e.we = 4'b1111;        e.wdata = i.rs2;            end
    endcase
    if (!i.store) e.we = 4'b0000;
    sh = i.rdata >> (8 * int'(i.r));
    case (i.f3)
      3'b000:  e.data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  e.data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  e.data = {24'd0, sh[7:0]};
      3'b101:  e.data = {16'd0, sh[15:0]};
      default: e.data = i.rdata;
    endcase
    if (!i.load) e.data = i.alu;
    return e;
  endfunction

  task automatic tick();
    instr_t cur;
    exp_t   m;
    logic   exp_req, hs;
    @(negedge clk);
    cur = (prog.size() > 0) ? prog[0] : mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, '0, 2'd0, 32'd0, 0, 32'd0);
    ex_valid = cur.valid; ex_load = cur.load; ex_store = cur.store;
    ex_funct3 = cur.f3;   ex_wb_en = cur.wb;  ex_rd_index = cur.rd;
    alu_out = cur.alu;    dm_addr = cur.addr; remainder = cur.r;
    rs2_data_out = cur.rs2;
    m = sb[0];
    exp_req = m.req && !m_done;
    if (exp_req) dm_ready = (req_cnt >= m.delay);
    else         dm_ready = idle_ready | ($urandom_range(0, 1) == 1);
    dm_rdata = (exp_req && dm_ready) ? m.rdata : $urandom();
    #1;
    check("dm_req", 32'(dm_req), 32'(exp_req));
    check("mem_stall", 32'(mem_stall), 32'(exp_req));
    check("misalign", 32'(misalign), 32'(m.mis));
    check("fwd", MEM_forward_data, m.alu);
    if (exp_req) begin
      check("dm_we", 32'(dm_we), 32'(m.we));
      check("dm_addr_o", 32'(dm_addr_o), 32'(m.addr));
      if (m.store) check("dm_wdata", dm_wdata, m.wdata);
    end else begin
      check("dm_we_idle", 32'(dm_we), 32'd0);
    end
    hs = exp_req && dm_ready;
    @(posedge clk);
    #1;
    if (exp_req) req_cnt++;
    if (hs) m_done = 1'b1;
    if (!exp_req) begin
      void'(sb.pop_front());
      check("wb_en", 32'(wb_en), 32'(m.en));
      if (m.en) begin
        check("wb_rd", 32'(wb_rd_index), 32'(m.rd));
        check("wb_data", wb_data, m.data);
      end
      sb.push_back(mk_exp(cur));
      if (prog.size() > 0) void'(prog.pop_front());
      m_done  = 1'b0;
      req_cnt = 0;
    end
  endtask

  task automatic run_prog();
    int guard = 0;
    while (prog.size() > 0 && guard < 400) begin
      tick();
      guard++;
    end
    check("prog_timeout", 32'(prog.size()), 32'd0);
    repeat (5) tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req"},   32'(dm_req), 32'd0);
    check({pfx, "_we"},    32'(dm_we), 32'd0);
    check({pfx, "_wdata"}, dm_wdata, 32'd0);
    check({pfx, "_addr"},  32'(dm_addr_o), 32'd0);
    check({pfx, "_stall"}, 32'(mem_stall), 32'd0);
    check({pfx, "_fwd"},   MEM_forward_data, 32'd0);
    check({pfx, "_mis"},   32'(misalign), 32'd0);
    check({pfx, "_wben"},  32'(wb_en), 32'd0);
    check({pfx, "_wbrd"},  32'(wb_rd_index), 32'd0);
    check({pfx, "_wbdat"}, wb_data, 32'd0);
  endtask

  task automatic restart_model();
    sb.delete();
    sb.push_back(mk_exp(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 32'd0, '0, 2'd0, 32'd0, 0, 32'd0)));
    m_done  = 1'b0;
    req_cnt = 0;
  endtask

  initial begin
    rst = 1'b0;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wb_en = 1'b0;
    ex_funct3 = 3'd0; ex_rd_index = 5'd0; alu_out = 32'd0; dm_addr = '0;
    remainder = 2'd0; rs2_data_out = 32'd0; dm_ready = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b1;
    restart_model();

    // ALU, loads/stores of every size, misaligned and bubble slots
    prog.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5,  32'h0000_1234, 14'h0000, 2'd0, 32'h0, 0, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd6,  32'h0000_0040, 14'h0010, 2'd0, 32'h0, 0, 32'hDEADBEEF));
    prog.push_back(mk(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0,  32'h0000_0048, 14'h0012, 2'd2, 32'h0000_00A5, 3, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 5'd7,  32'h0000_004F, 14'h0013, 2'd3, 32'h0, 1, 32'h8012_3456));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 5'd8,  32'h0000_004F, 14'h0013, 2'd3, 32'h0, 0, 32'h8012_3456));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 5'd9,  32'h0000_0052, 14'h0014, 2'd2, 32'h0, 2, 32'hBEEF_0000));
    prog.push_back(mk(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0,  32'h0000_0055, 14'h0020, 2'd1, 32'h1122_3344, 0, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 5'd11, 32'h0000_0062, 14'h0021, 2'd2, 32'h0, 0, 32'h8001_5555));
    prog.push_back(mk(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0,  32'h0000_0065, 14'h0022, 2'd1, 32'h0000_BEEF, 1, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 5'd12, 32'h0000_0067, 14'h0023, 2'd3, 32'h0, 0, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd15, 32'h0000_006A, 14'h0024, 2'd2, 32'h0, 0, 32'h0));
    prog.push_back(mk(1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 5'd16, 32'h0000_0077, 14'h0025, 2'd0, 32'h0, 0, 32'h0));
    prog.push_back(mk(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0,  32'h0000_0080, 14'h0030, 2'd0, 32'hCAFE_BABE, 2, 32'h0));
    run_prog();

    // dm_ready held high: ALU then back-to-back loads
    idle_ready = 1'b1;
    prog.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 5'd10, 32'hCAFE_F00D, 14'h0000, 2'd0, 32'h0, 0, 32'h0));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd13, 32'h0000_0100, 14'h0040, 2'd0, 32'h0, 0, 32'h1111_1111));
    prog.push_back(mk(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd14, 32'h0000_0104, 14'h0041, 2'd0, 32'h0, 0, 32'h2222_2222));
    run_prog();
    idle_ready = 1'b0;

    // reset asserted while an SH waits in BUSY
    prog.push_back(mk(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0000_0200, 14'h0050, 2'd2, 32'h0000_1357, 50, 32'h0));
    repeat (3) tick();
    check("busy_req", 32'(dm_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("rstbusy");
    prog.delete();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_wb_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    restart_model();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage that consumes the execute-stage results: ALU result, word address, byte offset and store data.
- Registers these into the M pipeline register and drives the data-memory request/ready handshake with byte strobes.
- Aligns and sign-extends load data, then presents the M-stage forwarding value and the registered writeback bundle.
- Raises mem_stall so earlier stages hold while a memory access is outstanding.

Parameters:
- ADDR_W, 14, word-address width of the data memory (byte offset carried separately as 2 bits).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ex_valid  in  1  EXE slot holds a real instruction (0 = bubble)
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store
- ex_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_wb_en  in  1  instruction writes rd
- ex_rd_index  in  5  destination register
- alu_out  in  32  ALU result
- dm_addr  in  ADDR_W  word address
- remainder  in  2  byte offset within the word
- rs2_data_out  in  32  store data, already forwarded
- dm_req  out  1  memory request
- dm_we  out  4  byte write strobes (0000 = read)
- dm_addr_o  out  ADDR_W  request word address
- dm_wdata  out  32  store data shifted to lane
- dm_ready  in  1  memory accepts/completes the request this cycle
- dm_rdata  in  32  read data, valid when dm_ready=1
- mem_stall  out  1  hold IF/ID/EXE and this stage's input
- MEM_forward_data  out  32  M-register alu_out, for the EXE forwarding muxes
- misalign  out  1  1-cycle pulse: misaligned access dropped
- wb_en  out  1  W-register write enable
- wb_rd_index  out  5  W-register rd
- wb_data  out  32  W-register data (load result or alu_out)

Behaviour:
- Reset (rst=0, async): M and W registers clear; FSM=IDLE; every output 0.
- Reg_M loads all ex_* inputs when mem_stall=0; it holds otherwise.
- M_memop = M_valid & (M_load | M_store).
- Alignment rule:
  - H access with remainder=3 is misaligned.
  - W access with remainder≠0 is misaligned.
  - A misaligned access issues no request, pulses misalign for 1 cycle, costs no stall, and forces W wb_en=0.
- FSM states IDLE, BUSY, DONE:
  - IDLE: dm_req = M_memop & aligned. If dm_req & dm_ready → DONE. If dm_req & !dm_ready → BUSY.
  - BUSY: dm_req=1 with address/strobes/data held stable. Stay until dm_ready, then → DONE.
  - DONE: dm_req=0. M and W advance at the cycle end. → IDLE.
- Load data is captured into an internal register on the dm_ready cycle.
- mem_stall = M_memop & aligned & (state≠DONE). Minimum cost is 1 stall cycle per memory op; each dm_ready wait cycle adds 1.
- Store lane rules (M_remainder = r):
  - SB: dm_we = 0001<<r; dm_wdata = rs2[7:0] replicated to all 4 bytes.
  - SH: dm_we = 0011<<r; dm_wdata = rs2[15:0] replicated to both halves.
  - SW: dm_we = 1111; dm_wdata = rs2.
- Loads: dm_we=0000. Byte = rdata[8r+7:8r]; half = rdata[8r+15:8r]. LB/LH sign-extend; LBU/LHU zero-extend.
- W register loads when mem_stall=0:
  - wb_en = M_valid & M_wb_en & !misalign.
  - wb_rd_index = M_rd.
  - wb_data = captured load data if M_load, else M alu_out.
- A bubble entering M (ex_valid=0) produces wb_en=0 in W.
- MEM_forward_data = M alu_out, combinational from Reg_M; a load's value is not forwarded from M.
- dm_ready outside IDLE-with-request or BUSY is ignored.
- Reset asserted in BUSY: dm_req drops immediately (async); no write is retried after release.
- Back-to-back memory ops: the DONE→IDLE cycle of op N is the first request cycle of op N+1.

Test Plan:
- LW at dm_addr=0x0010, r=0, dm_ready on the first request cycle, rdata=0xDEADBEEF → dm_req high 1 cycle, dm_we=0000, mem_stall high 1 cycle, wb_data=0xDEADBEEF, wb_en=1.
- SB at r=2, rs2=0x000000A5, dm_ready delayed 3 cycles → dm_we=0100, dm_wdata=0xA5A5A5A5 held stable 4 cycles, mem_stall high 4 cycles, wb_en=0.
- LB at r=3 with rdata=0x80xxxxxx → wb_data=0xFFFFFF80; LBU on the same data → wb_data=0x00000080; LHU at r=2 with rdata=0xBEEF0000 → 0x0000BEEF.
- SW at r=1 → no dm_req, misalign pulse, mem_stall=0, wb_en=0 next cycle.
- ALU op then back-to-back LW, LW with dm_ready held high → ALU result appears on MEM_forward_data the next cycle; each load stalls exactly 1 cycle; 2 consecutive wb_en pulses with the correct data.
- Assert rst in BUSY during SH → dm_req=0 immediately, all outputs 0; after release with ex_valid=0, no request is issued.
